seg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-segment encoder. Snoops a multiplexed 7-segment scan bus (digit select plus 9-bit segment pattern), waits until each scanned position has settled, and maps every settled pattern back to its 4-bit hex code, giving one register per digit position. Used in self-check and loopback paths so the digits shown on the display can be read back as numbers.

---
 rtl/seg_scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - settles a multiplexed 7-segment scan bus and decodes each position back to hex
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [8:0]              seg,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic                    frame_done,
    output logic                    err,
    output logic [2:0]              err_pos
);
    localparam int SW = NUM_DIGITS + 8;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t                state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [SW-1:0]         s_q, s_p;
    logic [NUM_DIGITS-1:0] an_q, visited;
    logic [6:0]            pat_q;
    logic                  dp_q;
    logic                  one_hot, changed, commit, legal;
    logic [3:0]            code;
    logic [2:0]            pos;
    logic                  unused_seg8;

    assign unused_seg8 = seg[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
            s_p <= '0;
        end else begin
            s_q <= {an, seg[7:0]};
            s_p <= s_q;
        end
    end

    assign an_q    = s_q[SW-1:8];
    assign dp_q    = s_q[7];
    assign pat_q   = s_q[6:0];
    assign one_hot = $onehot(an_q);
    assign changed = (s_q != s_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A change always restarts the stability count at 1 because the new value
    // has already been sampled once by the time it is compared.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (one_hot) begin
                    state_nx = SETTLE;
                    cnt_nx   = 8'd1;
                end else begin
                    cnt_nx = 8'd0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_nx = one_hot ? SETTLE : IDLE;
                    cnt_nx   = one_hot ? 8'd1 : 8'd0;
                end else if (cnt == 8'(STABLE_CYCLES - 1)) begin
                    commit   = 1'b1;
                    state_nx = HELD;
                    cnt_nx   = 8'(STABLE_CYCLES);
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            HELD: begin
                if (changed) begin
                    state_nx = one_hot ? SETTLE : IDLE;
                    cnt_nx   = one_hot ? 8'd1 : 8'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_comb begin
        legal = 1'b1;
        code  = 4'h0;
        case (pat_q)
            7'h3F: code = 4'h0;
            7'h06: code = 4'h1;
            7'h5B: code = 4'h2;
            7'h4F: code = 4'h3;
            7'h66: code = 4'h4;
            7'h6D: code = 4'h5;
            7'h7D: code = 4'h6;
            7'h07: code = 4'h7;
            7'h7F: code = 4'h8;
            7'h6F: code = 4'h9;
            7'h77: code = 4'hA;
            7'h7C: code = 4'hB;
            7'h39: code = 4'hC;
            7'h5E: code = 4'hD;
            7'h79: code = 4'hE;
            7'h71: code = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_q[i]) pos = 3'(i);
        end
    end

    // Commits only happen with a one-hot an_q, so an_q doubles as the position mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            dp          <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_pos     <= 3'd0;
            visited     <= '0;
        end else begin
            update     <= commit;
            frame_done <= commit && ((visited | an_q) == '1);
            if (err_clr) err <= 1'b0;
            if (commit) begin
                visited     <= ((visited | an_q) == '1) ? '0 : (visited | an_q);
                dp          <= (dp & ~an_q) | (dp_q ? an_q : '0);
                digit_valid <= (digit_valid & ~an_q) | (legal ? an_q : '0);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_q[i] && legal) digits[4*i +: 4] <= code;
                end
                if (!legal && pat_q != 7'h00) begin
                    err     <= 1'b1;
                    err_pos <= pos;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;
    localparam int ND = 4;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] an;
    logic [8:0]    seg;
    logic          err_clr;
    logic [15:0]   digits;
    logic [ND-1:0] dp, digit_valid;
    logic          update, frame_done, err;
    logic [2:0]    err_pos;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .err_clr(err_clr),
        .digits(digits), .dp(dp), .digit_valid(digit_valid), .update(update),
        .frame_done(frame_done), .err(err), .err_pos(err_pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic        err;
        logic [2:0]  err_pos;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_valid, m_visited;
    logic        m_err;
    logic [2:0]  m_err_pos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h10;  7'h06: return 5'h11;  7'h5B: return 5'h12;  7'h4F: return 5'h13;
            7'h66: return 5'h14;  7'h6D: return 5'h15;  7'h7D: return 5'h16;  7'h07: return 5'h17;
            7'h7F: return 5'h18;  7'h6F: return 5'h19;  7'h77: return 5'h1A;  7'h7C: return 5'h1B;
            7'h39: return 5'h1C;  7'h5E: return 5'h1D;  7'h79: return 5'h1E;  7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_digits = '0; m_dp = '0; m_valid = '0; m_visited = '0;
        m_err = 1'b0; m_err_pos = 3'd0;
    endtask

    // Called right after driving pins (#1 past an edge); the next edge samples them.
    task automatic expect_commit(input logic [3:0] a, input logic [8:0] s);
        exp_t e;
        logic [4:0] d;
        int p;
        d = dec(s[6:0]);
        p = 0;
        for (int i = 0; i < ND; i++) if (a[i]) p = i;
        if (d[4]) m_digits[4*p +: 4] = d[3:0];
        m_valid[p] = d[4];
        m_dp[p]    = s[7];
        if (!d[4] && s[6:0] != 7'h00) begin
            m_err = 1'b1;
            m_err_pos = 3'(p);
        end
        e.fd      = ((m_visited | a) == 4'hF);
        m_visited = e.fd ? 4'h0 : (m_visited | a);
        e.cyc     = cyc + 1 + S;
        e.digits  = m_digits;
        e.dp      = m_dp;
        e.valid   = m_valid;
        e.err     = m_err;
        e.err_pos = m_err_pos;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] a, input logic [8:0] s, input int n);
        an  = a;
        seg = s;
        if ($onehot(a) && n >= S) expect_commit(a, s);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && update) begin
            if (sb.size() == 0) begin
                chk("unexpected_update", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("commit_cycle", cyc, mon_e.cyc);
                chk("digits", {16'h0, digits}, {16'h0, mon_e.digits});
                chk("dp", {28'h0, dp}, {28'h0, mon_e.dp});
                chk("digit_valid", {28'h0, digit_valid}, {28'h0, mon_e.valid});
                chk("err", {31'h0, err}, {31'h0, mon_e.err});
                chk("err_pos", {29'h0, err_pos}, {29'h0, mon_e.err_pos});
                chk("frame_done", {31'h0, frame_done}, {31'h0, mon_e.fd});
            end
        end else if (!rst && frame_done) begin
            chk("stray_frame_done", 32'd1, 32'd0);
        end
    end

    initial begin
        rst = 1'b1; an = '0; seg = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", {16'h0, digits}, 32'h0);
        chk("rst_dp", {28'h0, dp}, 32'h0);
        chk("rst_valid", {28'h0, digit_valid}, 32'h0);
        chk("rst_update", {31'h0, update}, 32'h0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_pos", {29'h0, err_pos}, 32'h0);
        rst = 1'b0;

        drive(4'b0001, 9'h05B, 10);
        chk("t1_digit0", {28'h0, digits[3:0]}, 32'h2);
        chk("t1_valid", {28'h0, digit_valid}, 32'h1);
        chk("t1_err", {31'h0, err}, 32'h0);

        drive(4'b0001, 9'h03F, 6);
        drive(4'b0010, 9'h006, 6);
        drive(4'b0100, 9'h07C, 6);
        drive(4'b1000, 9'h0F1, 6);
        drive(4'b0000, 9'h000, 2);
        chk("t2_digits", {16'h0, digits}, 32'hFB10);
        chk("t2_dp", {28'h0, dp}, 32'h8);

        drive(4'b0010, 9'h05B, 3);
        drive(4'b0010, 9'h04F, 4);

        drive(4'b0100, 9'h049, 5);
        an  = 4'b1000;
        seg = 9'h04A;
        expect_commit(an, seg);
        repeat (S) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_held", {31'h0, err}, 32'h1);
        chk("t4_err_pos", {29'h0, err_pos}, 32'h3);
        chk("t4_digits_kept", {16'h0, digits}, {16'h0, m_digits});
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 1'b0;
        chk("t4_err_cleared", {31'h0, err}, 32'h0);

        drive(4'b0011, 9'h05B, 20);
        drive(4'b0000, 9'h06F, 20);
        drive(4'b0001, 9'h000, 6);
        chk("t5_blank_valid", {31'h0, digit_valid[0]}, 32'h0);
        chk("t5_blank_err", {31'h0, err}, 32'h0);
        drive(4'b0001, 9'h106, 6);

        an  = 4'b0100;
        seg = 9'h07D;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_digits", {16'h0, digits}, 32'h0);
        chk("t6_valid", {28'h0, digit_valid}, 32'h0);
        chk("t6_dp", {28'h0, dp}, 32'h0);
        chk("t6_update", {31'h0, update}, 32'h0);
        chk("t6_err_pos", {29'h0, err_pos}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        expect_commit(an, seg);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_digits_after", {16'h0, digits}, 32'h0600);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
